// File: rtl/dma_io_pkg.sv
// Shared constants for the UART/BRAM byte DMA: state encodings, control codes
// and default widths.
package dma_io_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_CNT_W  = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_RX_READ  = 3'd2;
    localparam logic [2:0] ST_RX_WRITE = 3'd3;
    localparam logic [2:0] ST_TX_READ  = 3'd4;
    localparam logic [2:0] ST_TX_SEND  = 3'd5;
    localparam logic [2:0] ST_TX_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_START    = ST_START,
        S_RX_READ  = ST_RX_READ,
        S_RX_WRITE = ST_RX_WRITE,
        S_TX_READ  = ST_TX_READ,
        S_TX_SEND  = ST_TX_SEND,
        S_TX_WAIT  = ST_TX_WAIT,
        S_DONE     = ST_DONE
    } state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_RX   = 2'b01;
    localparam logic [1:0] CTRL_TX   = 2'b10;

endpackage

// File: rtl/dma_controller_io_addr_cnt.sv
// Loadable BRAM address incrementer paired with a byte down-counter.
// The address wraps naturally at 2^ADDR_W; 'last' flags the final byte.
module dma_addr_cnt
    import dma_io_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  base_cnt,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  cnt,
    output logic              zero,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = base_addr;
            cnt_d  = base_cnt;
        end else if (step) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dma_controller_io.sv
// Byte DMA between the UART RX FIFO / transmitter and a byte-addressed BRAM.
// Define DMA_STATUS_EN to add the o_Xfer_Count progress output.
module dma_controller_io
    import dma_io_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [1:0]        i_Control,
    input  logic              i_Bus_Grant,
    output logic              o_Bus_Request,
    input  logic [ADDR_W-1:0] bram_pointer,
    input  logic [CNT_W-1:0]  i_Data_Counter,
    input  logic [7:0]        i_uart_rx,
    input  logic              i_uart_rx_valid,
    output logic              o_Read_Flag,
    output logic              o_Tx_Send,
    output logic [7:0]        o_uart_tx,
    output logic              o_uart_tx_dv,
    input  logic              i_Tx_Done,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_we,
    output logic [7:0]        o_bram_wdata,
    input  logic [7:0]        i_bram_rdata,
    output logic              o_Done,
    output logic [2:0]        r_SM_Main
`ifdef DMA_STATUS_EN
    ,
    output logic [CNT_W-1:0]  o_Xfer_Count
`endif
);

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] data_q, data_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_dv_q, tx_dv_d;
    logic       load, step, read_flag, bram_we;
    logic       cnt_zero, cnt_last;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;

    dma_addr_cnt #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_addr_cnt (
        .clk       (i_Clock),
        .rst_n     (i_Reset),
        .load      (load),
        .step      (step),
        .base_addr (bram_pointer),
        .base_cnt  (i_Data_Counter),
        .addr      (addr),
        .cnt       (cnt),
        .zero      (cnt_zero),
        .last      (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        mode_d    = mode_q;
        data_d    = data_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        read_flag = 1'b0;
        bram_we   = 1'b0;
        case (state_q)
            // A transfer only starts after control has been seen idle (armed).
            S_IDLE: begin
                if (i_Control == CTRL_IDLE || i_Control == 2'b11) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    load    = 1'b1;
                    mode_d  = i_Control;
                    armed_d = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_zero)                state_d = S_DONE;
                else if (mode_q == CTRL_TX)  state_d = S_TX_READ;
                else                         state_d = S_RX_READ;
            end
            S_RX_READ: begin
                if (i_Bus_Grant && i_uart_rx_valid) begin
                    read_flag = 1'b1;
                    data_d    = i_uart_rx;
                    state_d   = S_RX_WRITE;
                end
            end
            S_RX_WRITE: begin
                if (i_Bus_Grant) begin
                    bram_we = 1'b1;
                    step    = 1'b1;
                    state_d = cnt_last ? S_DONE : S_RX_READ;
                end
            end
            S_TX_READ: begin
                if (i_Bus_Grant) state_d = S_TX_SEND;
            end
            // BRAM data is valid here, one cycle after the address was issued.
            S_TX_SEND: begin
                tx_byte_d = i_bram_rdata;
                tx_dv_d   = 1'b1;
                state_d   = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (i_Tx_Done) begin
                    step    = 1'b1;
                    state_d = cnt_last ? S_DONE : S_TX_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b1;
            mode_q    <= CTRL_IDLE;
            data_q    <= 8'h00;
            tx_byte_q <= 8'h00;
            tx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
        end
    end

`ifdef DMA_STATUS_EN
    logic [CNT_W-1:0] xfer_q, xfer_d;

    always_comb begin
        xfer_d = xfer_q;
        if (load)      xfer_d = '0;
        else if (step) xfer_d = xfer_q + CNT_W'(1);
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) xfer_q <= '0;
        else          xfer_q <= xfer_d;
    end

    assign o_Xfer_Count = xfer_q;
`endif

    assign o_Bus_Request = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_Read_Flag   = read_flag;
    assign o_bram_we     = bram_we;
    assign o_bram_addr   = addr;
    assign o_bram_wdata  = data_q;
    assign o_uart_tx     = tx_byte_q;
    assign o_uart_tx_dv  = tx_dv_q;
    assign o_Tx_Send     = (state_q == S_TX_READ) || (state_q == S_TX_SEND) ||
                           (state_q == S_TX_WAIT);
    assign o_Done        = (state_q == S_DONE);
    assign r_SM_Main     = state_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_dma_controller_io.sv
// Scoreboard bench for dma_controller_io: FIFO, BRAM and transmitter models,
// expected writes/bytes queued by stimulus and checked by a negedge monitor.
module tb_dma_controller_io;

    logic        i_Clock = 1'b0;
    logic        i_Reset;
    logic [1:0]  i_Control;
    logic        i_Bus_Grant;
    logic        o_Bus_Request;
    logic [31:0] bram_pointer;
    logic [31:0] i_Data_Counter;
    logic [7:0]  i_uart_rx;
    logic        i_uart_rx_valid;
    logic        o_Read_Flag;
    logic        o_Tx_Send;
    logic [7:0]  o_uart_tx;
    logic        o_uart_tx_dv;
    logic        i_Tx_Done;
    logic [31:0] o_bram_addr;
    logic        o_bram_we;
    logic [7:0]  o_bram_wdata;
    logic [7:0]  i_bram_rdata = 8'h00;
    logic        o_Done;
    logic [2:0]  r_SM_Main;
`ifdef DMA_STATUS_EN
    logic [31:0] o_Xfer_Count;
`endif

    int total = 0;
    int bad = 0;
    int pop_count = 0;
    int dv_count = 0;

    logic [31:0] exp_wr_addr[$];
    logic [7:0]  exp_wr_data[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_fifo[$];
    logic [7:0]  mem [logic [31:0]];

    always #5 i_Clock = ~i_Clock;

    dma_controller_io #(.ADDR_W(32), .CNT_W(32)) dut (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .i_Control       (i_Control),
        .i_Bus_Grant     (i_Bus_Grant),
        .o_Bus_Request   (o_Bus_Request),
        .bram_pointer    (bram_pointer),
        .i_Data_Counter  (i_Data_Counter),
        .i_uart_rx       (i_uart_rx),
        .i_uart_rx_valid (i_uart_rx_valid),
        .o_Read_Flag     (o_Read_Flag),
        .o_Tx_Send       (o_Tx_Send),
        .o_uart_tx       (o_uart_tx),
        .o_uart_tx_dv    (o_uart_tx_dv),
        .i_Tx_Done       (i_Tx_Done),
        .o_bram_addr     (o_bram_addr),
        .o_bram_we       (o_bram_we),
        .o_bram_wdata    (o_bram_wdata),
        .i_bram_rdata    (i_bram_rdata),
        .o_Done          (o_Done),
        .r_SM_Main       (r_SM_Main)
`ifdef DMA_STATUS_EN
        ,
        .o_Xfer_Count    (o_Xfer_Count)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] ctrl, input logic [31:0] base,
                                 input logic [31:0] count);
        i_Control      = ctrl;
        bram_pointer   = base;
        i_Data_Counter = count;
    endtask

    // Runs until o_Done is seen at a negedge; stall mode gives 2-cycle grant windows.
    task automatic runUntilDone(input int max_cyc, input bit stall, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (stall) i_Bus_Grant = ((i % 6) >= 4);
            @(negedge i_Clock);
            cyc = i + 1;
            if (o_Done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("done_seen", seen, 1'b1);
    endtask

    task automatic finishXfer(input string name);
        tick();
        i_Control   = 2'b00;
        i_Bus_Grant = 1'b1;
        @(negedge i_Clock);
        checkOutput({name, "_state_idle"}, r_SM_Main, 3'd0);
        tick();
    endtask

    // RX FIFO model: first-word-fall-through, popped after a sampled read strobe.
    initial begin
        bit p;
        i_uart_rx = 8'h00;
        i_uart_rx_valid = 1'b0;
        forever begin
            @(negedge i_Clock);
            p = o_Read_Flag;
            @(posedge i_Clock);
            #1;
            if (p) begin
                pop_count++;
                if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
            end
            i_uart_rx = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
            i_uart_rx_valid = (rx_fifo.size() > 0);
        end
    end

    always @(posedge i_Clock) begin
        i_bram_rdata <= mem.exists(o_bram_addr) ? mem[o_bram_addr] : 8'h00;
    end

    // Transmitter model: finishes each byte 10 cycles after its valid pulse.
    initial begin
        i_Tx_Done = 1'b0;
        forever begin
            @(negedge i_Clock);
            if (o_uart_tx_dv) begin
                repeat (10) @(posedge i_Clock);
                #1 i_Tx_Done = 1'b1;
                @(posedge i_Clock);
                #1 i_Tx_Done = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] ea;
        logic [7:0]  ed;
        forever begin
            @(negedge i_Clock);
            if (o_bram_we) begin
                checkOutput("we_needs_grant", i_Bus_Grant, 1'b1);
                if (exp_wr_addr.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             o_bram_addr, o_bram_wdata);
                end else begin
                    ea = exp_wr_addr.pop_front();
                    ed = exp_wr_data.pop_front();
                    checkOutput("wr_addr", o_bram_addr, ea);
                    checkOutput("wr_data", o_bram_wdata, ed);
                end
            end
            if (o_uart_tx_dv) begin
                dv_count++;
                checkOutput("tx_send_at_dv", o_Tx_Send, 1'b1);
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_tx: got 0x%0h expected none", o_uart_tx);
                end else begin
                    ed = exp_tx.pop_front();
                    checkOutput("tx_byte", o_uart_tx, ed);
                end
            end
            if (i_Tx_Done) checkOutput("tx_send_at_done", o_Tx_Send, 1'b1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int pops0;
        int busy;
        logic [7:0] rx_bytes [3];
        rx_bytes[0] = 8'h05; rx_bytes[1] = 8'h55; rx_bytes[2] = 8'hAA;

        i_Reset = 1'b0;
        i_Bus_Grant = 1'b0;
        applyStimulus(2'b00, 32'h0, 32'h0);
        tick();
        tick();
        @(negedge i_Clock);
        checkOutput("rst_state", r_SM_Main, 3'd0);
        checkOutput("rst_we", o_bram_we, 1'b0);
        checkOutput("rst_done", o_Done, 1'b0);
        checkOutput("rst_busreq", o_Bus_Request, 1'b0);
        checkOutput("rst_read_flag", o_Read_Flag, 1'b0);
        checkOutput("rst_tx_dv", o_uart_tx_dv, 1'b0);
        checkOutput("rst_tx_send", o_Tx_Send, 1'b0);
        checkOutput("rst_uart_tx", o_uart_tx, 8'h00);
        tick();
        i_Reset = 1'b1;
        tick();

        $display("[TB] RX basic");
        pops0 = pop_count;
        for (int i = 0; i < 3; i++) begin
            rx_fifo.push_back(rx_bytes[i]);
            exp_wr_addr.push_back(32'h100 + i);
            exp_wr_data.push_back(rx_bytes[i]);
        end
        tick();
        i_Bus_Grant = 1'b1;
        applyStimulus(2'b01, 32'h100, 32'd3);
        runUntilDone(100, 1'b0, cyc);
        checkOutput("rx_pops", pop_count - pops0, 3);
        checkOutput("rx_wr_pending", exp_wr_addr.size(), 0);
`ifdef DMA_STATUS_EN
        checkOutput("rx_xfer_count", o_Xfer_Count, 32'd3);
`endif
        finishXfer("rx");

        $display("[TB] grant stall");
        pops0 = pop_count;
        for (int i = 0; i < 3; i++) begin
            rx_fifo.push_back(rx_bytes[i]);
            exp_wr_addr.push_back(32'h100 + i);
            exp_wr_data.push_back(rx_bytes[i]);
        end
        tick();
        applyStimulus(2'b01, 32'h100, 32'd3);
        runUntilDone(300, 1'b1, cyc);
        checkOutput("stall_pops", pop_count - pops0, 3);
        checkOutput("stall_wr_pending", exp_wr_addr.size(), 0);
        finishXfer("stall");

        $display("[TB] address wrap");
        rx_fifo.push_back(8'h11);
        rx_fifo.push_back(8'h22);
        exp_wr_addr.push_back(32'hFFFF_FFFF); exp_wr_data.push_back(8'h11);
        exp_wr_addr.push_back(32'h0000_0000); exp_wr_data.push_back(8'h22);
        tick();
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2);
        runUntilDone(100, 1'b0, cyc);
        checkOutput("wrap_wr_pending", exp_wr_addr.size(), 0);
        finishXfer("wrap");

        $display("[TB] TX");
        mem[32'h20] = 8'h05;
        mem[32'h21] = 8'h7E;
        exp_tx.push_back(8'h05);
        exp_tx.push_back(8'h7E);
        dv_count = 0;
        applyStimulus(2'b10, 32'h20, 32'd2);
        runUntilDone(200, 1'b0, cyc);
        checkOutput("tx_dv_count", dv_count, 2);
        checkOutput("tx_pending", exp_tx.size(), 0);
`ifdef DMA_STATUS_EN
        checkOutput("tx_xfer_count", o_Xfer_Count, 32'd2);
`endif
        finishXfer("tx");

        $display("[TB] zero count and re-arm");
        rx_fifo.push_back(8'h33);
        tick();
        pops0 = pop_count;
        applyStimulus(2'b01, 32'h400, 32'd0);
        runUntilDone(3, 1'b0, cyc);
        checkOutput("zero_pops", pop_count - pops0, 0);
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge i_Clock);
            if (r_SM_Main != 3'd0 || o_Bus_Request) busy++;
        end
        checkOutput("rearm_busy_cycles", busy, 0);
        checkOutput("rearm_pops", pop_count - pops0, 0);
        tick();
        i_Control = 2'b00;
        tick();
        exp_wr_addr.push_back(32'h500);
        exp_wr_data.push_back(8'h33);
        applyStimulus(2'b01, 32'h500, 32'd1);
        runUntilDone(50, 1'b0, cyc);
        checkOutput("rearm_wr_pending", exp_wr_addr.size(), 0);
        finishXfer("rearm");

        $display("[TB] reset mid-RX");
        rx_fifo.push_back(8'h99);
        rx_fifo.push_back(8'h77);
        tick();
        applyStimulus(2'b01, 32'h300, 32'd5);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_Clock);
            if (o_Read_Flag) begin
                cyc = 1;
                break;
            end
            tick();
        end
        checkOutput("midrx_read_seen", cyc, 1);
        tick();
        i_Bus_Grant = 1'b0;
        i_Reset = 1'b0;
        i_Control = 2'b00;
        @(negedge i_Clock);
        checkOutput("midrx_in_write", r_SM_Main, 3'd3);
        tick();
        i_Bus_Grant = 1'b1;
        @(negedge i_Clock);
        checkOutput("midrx_rst_state", r_SM_Main, 3'd0);
        checkOutput("midrx_rst_we", o_bram_we, 1'b0);
        checkOutput("midrx_rst_read_flag", o_Read_Flag, 1'b0);
        tick();
        i_Reset = 1'b1;
        rx_fifo.delete();
        tick();
        tick();
        checkOutput("final_wr_pending", exp_wr_addr.size(), 0);
        checkOutput("final_tx_pending", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
